// File: rtl/loop_control_unit_pkg.sv
// Shared types and constants for the bracket-loop branch-resolution stage.
// Imported by the loop control unit and its testbench.
package loop_control_unit_pkg;

  localparam int LOOP_PC_WIDTH    = 16;
  localparam int LOOP_STACK_DEPTH = 16;
  localparam int LOOP_NEST_WIDTH  = 8;

  typedef logic [LOOP_PC_WIDTH-1:0] program_counter_t;

  typedef enum logic {
    LOOP_RUN  = 1'b0,
    LOOP_SKIP = 1'b1
  } loop_state_t;

  // Decode strobes for one instruction, as seen by the loop unit.
  typedef struct packed {
    logic is_open;
    logic is_close;
    logic data_zero;
  } control_t;

  function automatic int unsigned depth_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lifo_stack.sv
// Small LIFO with an always-visible top entry. Push wins over pop.
// Pushes when full and pops when empty are ignored and flagged.
module lifo_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             push_drop_o,
  output logic             pop_drop_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             do_push;
  logic             do_pop;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign wr_idx      = count_q[AW-1:0];
  assign top_idx     = AW'(count_q - 1'b1);
  assign top_o       = empty_o ? '0 : mem_q[top_idx];
  assign count_o     = count_q;

  assign do_push     = push_i & ~full_o;
  assign do_pop      = pop_i & ~empty_o & ~push_i;
  assign push_drop_o = push_i & full_o;
  assign pop_drop_o  = pop_i & empty_o;

  // NOTE: the entries are reset too, so a freshly reset stack reads back all zeros;
  // drop the array from the reset branch only if that guarantee is not needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_idx] <= data_i;
      count_q       <= count_q + 1'b1;
    end else if (do_pop) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/loop_control_unit.sv
// Bracket-loop branch resolution: drives the fetch PC mux and the skip gate.
// '[' pushes the loop body start; ']' jumps back or pops; zero-data '[' skips to its match.
module loop_control_unit
  import loop_control_unit_pkg::*;
#(
  parameter int PC_WIDTH    = LOOP_PC_WIDTH,
  parameter int STACK_DEPTH = LOOP_STACK_DEPTH,
  parameter int NEST_WIDTH  = LOOP_NEST_WIDTH,
  localparam int DW = $clog2(STACK_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                advance,
  input  logic                is_open,
  input  logic                is_close,
  input  logic                data_zero,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] pc_incr,
  output logic                pc_src,
  output logic [PC_WIDTH-1:0] pc_loaded,
  output logic                skip,
  output logic [DW-1:0]       depth,
  output logic                error
);

  loop_state_t           state_q, state_d;
  logic [NEST_WIDTH-1:0] nest_q, nest_d;
  logic                  error_q, error_d;

  logic                  push_req, pop_req;
  logic                  stk_full, stk_empty;
  logic                  push_drop, pop_drop;
  logic [PC_WIDTH-1:0]   stk_top;
  logic [DW-1:0]         stk_count;

  // Targets come from pc_incr; pc is only kept on the port for trace taps.
  logic unused_sig;
  assign unused_sig = ^{pc, stk_full};

  lifo_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_req & advance),
    .pop_i       (pop_req & advance),
    .data_i      (pc_incr),
    .top_o       (stk_top),
    .count_o     (stk_count),
    .full_o      (stk_full),
    .empty_o     (stk_empty),
    .push_drop_o (push_drop),
    .pop_drop_o  (pop_drop)
  );

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    nest_d   = nest_q;
    error_d  = error_q;
    push_req = 1'b0;
    pop_req  = 1'b0;
    pc_src   = 1'b0;
    skip     = (state_q == LOOP_SKIP);

    if (is_open && is_close) begin
      error_d = 1'b1;
    end else begin
      case (state_q)
        LOOP_RUN: begin
          if (is_open) begin
            if (data_zero) begin
              nest_d  = NEST_WIDTH'(1);
              state_d = LOOP_SKIP;
            end else begin
              push_req = 1'b1;
            end
          end else if (is_close) begin
            // An empty-stack ']' requests a pop so the stack flags the underflow.
            if (!data_zero && !stk_empty) pc_src  = 1'b1;
            else                          pop_req = 1'b1;
          end
        end
        LOOP_SKIP: begin
          if (is_open) begin
            if (&nest_q) error_d = 1'b1;
            else         nest_d  = nest_q + 1'b1;
          end else if (is_close) begin
            if (nest_q <= NEST_WIDTH'(1)) begin
              nest_d  = '0;
              state_d = LOOP_RUN;
            end else begin
              nest_d = nest_q - 1'b1;
            end
          end
        end
      endcase
    end

    if (push_drop || pop_drop) error_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOOP_RUN;
      nest_q  <= '0;
      error_q <= 1'b0;
    end else if (advance) begin
      state_q <= state_d;
      nest_q  <= nest_d;
      error_q <= error_d;
    end
  end

  assign pc_loaded = stk_top;
  assign depth     = stk_count;
  assign error     = error_q;

endmodule
